// File: rtl/fhe_lane_alu_seq.sv
// fhe_lane_alu_seq: one polynomial op per command, LANES-wide modular ALU
// in a 2-stage elastic pipeline between register-file read and writeback streams.
module fhe_lane_alu_seq #(
   parameter int LANES = 4,
   parameter int COEFF_W = 32,
   parameter int N = 1024,
   parameter longint unsigned Q = 132120577,
   parameter int NREG = 32,
   localparam int IDX_W = $clog2(NREG)
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     op_valid,
   output logic                     op_ready,
   input  logic [1:0]               op_mode,
   input  logic [IDX_W-1:0]         op_src0_idx,
   input  logic [IDX_W-1:0]         op_src1_idx,
   input  logic [IDX_W-1:0]         op_dst_idx,
   input  logic [COEFF_W-1:0]       op_scalar,
   output logic                     rf_start,
   output logic [IDX_W-1:0]         rf_src0_idx,
   output logic [IDX_W-1:0]         rf_src1_idx,
   input  logic                     src_valid,
   output logic                     src_ready,
   input  logic [LANES*COEFF_W-1:0] src0_data,
   input  logic [LANES*COEFF_W-1:0] src1_data,
   input  logic                     src_last,
   output logic                     wb_valid,
   input  logic                     wb_ready,
   output logic [IDX_W-1:0]         wb_idx,
   output logic [LANES*COEFF_W-1:0] wb_data,
   output logic                     wb_last,
   output logic                     busy,
   output logic                     done,
   output logic                     err
);
   localparam int BEATS = N / LANES;
   localparam int CNT_W = BEATS > 1 ? $clog2(BEATS) : 1;
   localparam logic [2*COEFF_W-1:0] QP = (2*COEFF_W)'(Q);
   localparam logic [2:0] S_IDLE = 3'd0, S_START = 3'd1, S_STREAM = 3'd2, S_DRAIN = 3'd3, S_DONE = 3'd4;
   localparam logic [1:0] M_ADD = 2'd0, M_SUB = 2'd1, M_SMUL = 2'd2;

   logic [2:0] state_q, state_d;
   logic [1:0] mode_q, mode_d;
   logic [IDX_W-1:0] src0_q, src0_d, src1_q, src1_d, dst_q, dst_d;
   logic [COEFF_W-1:0] scalar_q, scalar_d;
   logic err_q, err_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic s1_valid_q, s1_valid_d, s1_last_q, s1_last_d, s2_valid_q, s2_valid_d, s2_last_q, s2_last_d;
   logic [LANES-1:0][2*COEFF_W-1:0] raw, s1_raw_q, s1_raw_d;
   logic [LANES-1:0] brw, s1_brw_q, s1_brw_d;
   logic [LANES*COEFF_W-1:0] red, s2_data_q, s2_data_d;
   logic accept, advance, fire, final_beat, wb_fire;

   assign op_ready = state_q == S_IDLE;
   assign accept = op_valid && op_ready;
   assign advance = !s2_valid_q || wb_ready;
   assign src_ready = state_q == S_STREAM && advance;
   assign fire = src_valid && src_ready;
   assign final_beat = cnt_q == CNT_W'(BEATS - 1);
   assign wb_fire = s2_valid_q && wb_ready;

   for (genvar l = 0; l < LANES; l++) begin : g_lane
      logic [COEFF_W-1:0] a, b, dif;
      logic [COEFF_W:0] sum;
      logic [2*COEFF_W-1:0] prod;
      assign a = src0_data[l*COEFF_W +: COEFF_W];
      assign b = mode_q == M_SMUL ? scalar_q : src1_data[l*COEFF_W +: COEFF_W];
      assign sum = {1'b0, a} + {1'b0, b};
      assign dif = a - b;
      assign prod = {{COEFF_W{1'b0}}, a} * {{COEFF_W{1'b0}}, b};
      assign brw[l] = a < b;
      assign raw[l] = mode_q == M_ADD ? {{(COEFF_W-1){1'b0}}, sum}
                    : mode_q == M_SUB ? {{COEFF_W{1'b0}}, dif} : prod;
      // SUB wraps through Q in the wide domain; only the low COEFF_W bits are kept
      assign red[l*COEFF_W +: COEFF_W] = COEFF_W'(
         mode_q == M_ADD ? (s1_raw_q[l] >= QP ? s1_raw_q[l] - QP : s1_raw_q[l])
       : mode_q == M_SUB ? (s1_brw_q[l] ? s1_raw_q[l] + QP : s1_raw_q[l])
       : s1_raw_q[l] % QP);
   end

   always_comb begin
      state_d = state_q == S_IDLE   ? (accept ? S_START : S_IDLE)
              : state_q == S_START  ? S_STREAM
              : state_q == S_STREAM ? (fire && final_beat ? S_DRAIN : S_STREAM)
              : state_q == S_DRAIN  ? (wb_fire && s2_last_q ? S_DONE : S_DRAIN)
              : S_IDLE;
      mode_d = accept ? op_mode : mode_q;
      src0_d = accept ? op_src0_idx : src0_q;
      src1_d = accept ? op_src1_idx : src1_q;
      dst_d = accept ? op_dst_idx : dst_q;
      scalar_d = accept ? op_scalar : scalar_q;
      err_d = accept ? 1'b0 : (fire && (src_last != final_beat)) ? 1'b1 : err_q;
      cnt_d = accept ? '0 : fire ? cnt_q + 1'b1 : cnt_q;
      s1_valid_d = advance ? fire : s1_valid_q;
      s1_last_d = advance ? fire && final_beat : s1_last_q;
      s1_raw_d = advance ? raw : s1_raw_q;
      s1_brw_d = advance ? brw : s1_brw_q;
      s2_valid_d = advance ? s1_valid_q : s2_valid_q;
      s2_last_d = advance ? s1_last_q : s2_last_q;
      s2_data_d = advance ? red : s2_data_q;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= S_IDLE;
         mode_q <= '0;
         src0_q <= '0;
         src1_q <= '0;
         dst_q <= '0;
         scalar_q <= '0;
         err_q <= 1'b0;
         cnt_q <= '0;
         s1_valid_q <= 1'b0;
         s1_last_q <= 1'b0;
         s1_raw_q <= '0;
         s1_brw_q <= '0;
         s2_valid_q <= 1'b0;
         s2_last_q <= 1'b0;
         s2_data_q <= '0;
      end else begin
         state_q <= state_d;
         mode_q <= mode_d;
         src0_q <= src0_d;
         src1_q <= src1_d;
         dst_q <= dst_d;
         scalar_q <= scalar_d;
         err_q <= err_d;
         cnt_q <= cnt_d;
         s1_valid_q <= s1_valid_d;
         s1_last_q <= s1_last_d;
         s1_raw_q <= s1_raw_d;
         s1_brw_q <= s1_brw_d;
         s2_valid_q <= s2_valid_d;
         s2_last_q <= s2_last_d;
         s2_data_q <= s2_data_d;
      end
   end

   assign rf_start = state_q == S_START;
   assign rf_src0_idx = src0_q;
   assign rf_src1_idx = src1_q;
   assign wb_valid = s2_valid_q;
   assign wb_idx = dst_q;
   assign wb_data = s2_data_q;
   assign wb_last = s2_last_q;
   assign busy = state_q != S_IDLE;
   assign done = state_q == S_DONE;
   assign err = err_q;
endmodule

// File: tb/tb_fhe_lane_alu_seq.sv
// tb_fhe_lane_alu_seq: randomized ops checked against a plain modular-arithmetic
// reference, plus back-pressure, src_last error and mid-op reset scenarios.
module tb_fhe_lane_alu_seq;
   localparam int LANES = 4, COEFF_W = 32, N = 1024, NREG = 32, IDX_W = 5;
   localparam int BEATS = N / LANES, DW = LANES * COEFF_W;
   localparam longint unsigned Q = 132120577;

   logic clk, reset, op_valid, op_ready, rf_start, src_valid, src_ready, src_last;
   logic wb_valid, wb_ready, wb_last, busy, done, err;
   logic [1:0] op_mode;
   logic [IDX_W-1:0] op_src0_idx, op_src1_idx, op_dst_idx, rf_src0_idx, rf_src1_idx, wb_idx;
   logic [COEFF_W-1:0] op_scalar;
   logic [DW-1:0] src0_data, src1_data, wb_data;

   int n_tests = 0, n_fail = 0;
   int cyc_n = 0, done_n = 0, done_c = 0, start_n = 0, busy_n = 0;
   logic [DW-1:0] got_d[$];
   bit got_l[$];
   int got_c[$];
   logic [IDX_W-1:0] got_i[$];
   int acc_c[$];
   logic [DW-1:0] st_d[$];
   bit st_r[$];
   bit st_v[$];
   logic [DW-1:0] s0_mem[BEATS];
   logic [DW-1:0] s1_mem[BEATS];
   int cur_mode;
   longint unsigned cur_scalar;
   logic [IDX_W-1:0] cur_s0, cur_s1, cur_dst;
   bit to_flag;

   fhe_lane_alu_seq #(.LANES(LANES), .COEFF_W(COEFF_W), .N(N), .Q(Q), .NREG(NREG)) dut (
      .clk(clk), .reset(reset), .op_valid(op_valid), .op_ready(op_ready), .op_mode(op_mode),
      .op_src0_idx(op_src0_idx), .op_src1_idx(op_src1_idx), .op_dst_idx(op_dst_idx),
      .op_scalar(op_scalar), .rf_start(rf_start), .rf_src0_idx(rf_src0_idx),
      .rf_src1_idx(rf_src1_idx), .src_valid(src_valid), .src_ready(src_ready),
      .src0_data(src0_data), .src1_data(src1_data), .src_last(src_last), .wb_valid(wb_valid),
      .wb_ready(wb_ready), .wb_idx(wb_idx), .wb_data(wb_data), .wb_last(wb_last),
      .busy(busy), .done(done), .err(err));

   initial begin
      clk = 0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc_n <= cyc_n + 1;

   always @(negedge clk) begin
      if (wb_valid && wb_ready) begin
         got_d.push_back(wb_data);
         got_l.push_back(wb_last);
         got_c.push_back(cyc_n);
         got_i.push_back(wb_idx);
      end
      if (src_valid && src_ready) acc_c.push_back(cyc_n);
      if (done) begin
         done_n++;
         done_c = cyc_n;
      end
      if (rf_start) start_n++;
      if (busy) busy_n++;
   end

   function automatic longint unsigned model(int m, longint unsigned a, longint unsigned b, longint unsigned s);
      case (m)
         0: return (a + b) % Q;
         1: return (a + Q - b) % Q;
         2: return (a * s) % Q;
         default: return (a * b) % Q;
      endcase
   endfunction

   // scoreboard: index of the first beat whose data or last flag disagrees with the model, -1 if none
   function automatic int sb_first_err();
      longint unsigned a, b, e;
      for (int k = 0; k < BEATS; k++) begin
         if (k >= got_d.size()) return k;
         if (got_l[k] != (k == BEATS - 1)) return k;
         for (int l = 0; l < LANES; l++) begin
            a = longint'(s0_mem[k][l*COEFF_W +: COEFF_W]);
            b = longint'(s1_mem[k][l*COEFF_W +: COEFF_W]);
            e = model(cur_mode, a, b, cur_scalar);
            if (got_d[k][l*COEFF_W +: COEFF_W] != COEFF_W'(e)) return k;
         end
      end
      return -1;
   endfunction

   task automatic issue_op(int mode, longint unsigned sc);
      int g = 0;
      cur_s0 = IDX_W'($urandom_range(0, NREG - 1));
      cur_s1 = IDX_W'($urandom_range(0, NREG - 1));
      cur_dst = IDX_W'($urandom_range(0, NREG - 1));
      op_valid = 1;
      op_mode = 2'(mode);
      op_src0_idx = cur_s0;
      op_src1_idx = cur_s1;
      op_dst_idx = cur_dst;
      op_scalar = COEFF_W'(sc);
      while (!op_ready && g < 100) begin
         @(posedge clk); #1;
         g++;
      end
      if (g >= 100) to_flag = 1;
      @(posedge clk); #1;
      op_valid = 0;
   endtask

   task automatic run(int mode, longint unsigned sc, int kind, longint unsigned va, longint unsigned vb,
                      int last_x, int stall_at, int abort_at, bit rnd);
      int k = 0, cyc = 0, stall = 0, g = 0, d0;
      bit stall_used = 0, acc;
      longint unsigned a, b;
      for (int j = 0; j < BEATS; j++)
         for (int l = 0; l < LANES; l++) begin
            a = kind == 0 ? va : kind == 1 ? longint'($urandom_range(0, 32'(Q - 1))) : longint'(j * LANES + l) % Q;
            b = kind == 0 ? vb : kind == 1 ? longint'($urandom_range(0, 32'(Q - 1))) : longint'(j * LANES + l + 1000) % Q;
            s0_mem[j][l*COEFF_W +: COEFF_W] = COEFF_W'(a);
            s1_mem[j][l*COEFF_W +: COEFF_W] = COEFF_W'(b);
         end
      got_d.delete(); got_l.delete(); got_c.delete(); got_i.delete(); acc_c.delete();
      st_d.delete(); st_r.delete(); st_v.delete();
      done_n = 0; start_n = 0; busy_n = 0; to_flag = 0;
      cur_mode = mode;
      cur_scalar = sc;
      issue_op(mode, sc);
      while (k < BEATS && cyc < 5000) begin
         if (k == stall_at && !stall_used) begin
            stall = 5;
            stall_used = 1;
         end
         wb_ready = stall > 0 ? 1'b0 : rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
         src_valid = 1;
         src0_data = s0_mem[k];
         src1_data = s1_mem[k];
         src_last = (k == BEATS - 1) || (k == last_x);
         #4;
         if (stall > 0) begin
            st_d.push_back(wb_data);
            st_r.push_back(src_ready);
            st_v.push_back(wb_valid);
         end
         acc = src_ready;
         @(posedge clk); #1;
         if (stall > 0) stall--;
         if (acc) k++;
         cyc++;
         if (abort_at >= 0 && k == abort_at) break;
      end
      if (cyc >= 5000) to_flag = 1;
      src_valid = 0;
      src_last = 0;
      wb_ready = 1;
      if (abort_at < 0) begin
         d0 = done_n;
         while (done_n == d0 && g < 2000) begin
            @(negedge clk); #1;
            g++;
         end
         if (g >= 2000) to_flag = 1;
         @(posedge clk); #1;
      end
   endtask

   task automatic test_reset();
      reset = 0;
      op_valid = 0; op_mode = 0; op_src0_idx = 0; op_src1_idx = 0; op_dst_idx = 0; op_scalar = 0;
      src_valid = 0; src0_data = 0; src1_data = 0; src_last = 0; wb_ready = 1;
      #12;
      n_tests++;
      if ({op_ready, src_ready, rf_start, wb_valid, wb_last, busy, done, err} !== 8'b1000_0000) begin
         n_fail++;
         $display("FAIL reset_ctrl: got %b required 10000000",
                  {op_ready, src_ready, rf_start, wb_valid, wb_last, busy, done, err});
      end
      n_tests++;
      if ({wb_data, wb_idx, rf_src0_idx, rf_src1_idx} !== '0) begin
         n_fail++;
         $display("FAIL reset_data: got wb_data=%h idx=%0d/%0d/%0d required all 0", wb_data, wb_idx, rf_src0_idx, rf_src1_idx);
      end
      @(posedge clk); #1;
      reset = 1;
      @(posedge clk); #1;
   endtask

   task automatic test_add();
      int bad, lat_bad = 0, idx_bad = 0;
      run(0, 0, 0, Q - 1, 2, -1, -1, -1, 0);
      n_tests++;
      if (to_flag !== 0) begin n_fail++; $display("FAIL add_timeout: got timeout required none"); end
      n_tests++;
      if (got_d.size() != BEATS) begin n_fail++; $display("FAIL add_beats: got %0d required %0d", got_d.size(), BEATS); end
      bad = sb_first_err();
      n_tests++;
      if (bad != -1) begin n_fail++; $display("FAIL add_data: first bad beat %0d required none", bad); end
      n_tests++;
      if (got_d[0][COEFF_W-1:0] !== 32'd1) begin n_fail++; $display("FAIL add_lane_value: got %0d required 1", got_d[0][COEFF_W-1:0]); end
      for (int k = 0; k < BEATS; k++) begin
         if (k >= acc_c.size() || k >= got_c.size() || got_c[k] != acc_c[k] + 2) lat_bad++;
         if (k >= got_i.size() || got_i[k] !== cur_dst) idx_bad++;
      end
      n_tests++;
      if (lat_bad != 0) begin n_fail++; $display("FAIL add_latency: got %0d beats off t+2 required 0", lat_bad); end
      n_tests++;
      if (idx_bad != 0) begin n_fail++; $display("FAIL add_wb_idx: got %0d wrong beats required 0 (dst %0d)", idx_bad, cur_dst); end
      n_tests++;
      if (done_n != 1 || got_c.size() == 0 || done_c != got_c[got_c.size()-1] + 1) begin
         n_fail++;
         $display("FAIL add_done: got %0d pulses at cycle %0d required 1 pulse one cycle after last wb", done_n, done_c);
      end
      n_tests++;
      if (start_n != 1) begin n_fail++; $display("FAIL add_rf_start: got %0d cycles required 1", start_n); end
      n_tests++;
      if (busy_n != BEATS + 4) begin n_fail++; $display("FAIL add_busy: got %0d cycles required %0d", busy_n, BEATS + 4); end
      n_tests++;
      if ({rf_src0_idx, rf_src1_idx, err, busy} !== {cur_s0, cur_s1, 1'b0, 1'b0}) begin
         n_fail++;
         $display("FAIL add_post: got src=%0d/%0d err=%b busy=%b required %0d/%0d 0 0", rf_src0_idx, rf_src1_idx, err, busy, cur_s0, cur_s1);
      end
   endtask

   task automatic test_modes();
      int md[5] = '{1, 1, 2, 3, 3};
      longint unsigned va[5] = '{3, 5, Q - 1, Q - 1, 0};
      longint unsigned vb[5] = '{5, 3, 7, 2, 12345};
      longint unsigned sc[5] = '{0, 0, Q - 1, 0, 0};
      longint unsigned ex[5] = '{Q - 2, 2, 1, Q - 2, 0};
      int bad;
      for (int t = 0; t < 5; t++) begin
         run(md[t], sc[t], 0, va[t], vb[t], -1, -1, -1, 0);
         bad = sb_first_err();
         n_tests++;
         if (to_flag !== 0 || bad != -1 || got_d.size() != BEATS) begin
            n_fail++;
            $display("FAIL mode%0d_case%0d: got %0d beats first bad %0d timeout %b required %0d beats none 0", md[t], t, got_d.size(), bad, to_flag, BEATS);
         end
         n_tests++;
         if (got_d[BEATS-1][DW-1 -: COEFF_W] !== COEFF_W'(ex[t])) begin
            n_fail++;
            $display("FAIL mode%0d_case%0d_value: got %0d required %0d", md[t], t, got_d[BEATS-1][DW-1 -: COEFF_W], ex[t]);
         end
      end
   endtask

   task automatic test_random();
      int bad, m;
      longint unsigned sc;
      for (int t = 0; t < 4; t++) begin
         m = t;
         sc = longint'($urandom_range(0, 32'(Q - 1)));
         run(m, sc, 1, 0, 0, -1, -1, -1, 1);
         bad = sb_first_err();
         n_tests++;
         if (to_flag !== 0 || bad != -1 || got_d.size() != BEATS || done_n != 1) begin
            n_fail++;
            $display("FAIL random_mode%0d: got %0d beats first bad %0d done %0d timeout %b required %0d none 1 0", m, got_d.size(), bad, done_n, to_flag, BEATS);
         end
      end
   endtask

   task automatic test_backpressure();
      int bad, viol = 0;
      run(3, 0, 2, 0, 0, -1, 100, -1, 0);
      for (int i = 0; i < st_d.size(); i++)
         if (st_d[i] !== st_d[0] || st_r[i] !== 1'b0 || st_v[i] !== 1'b1) viol++;
      n_tests++;
      if (st_d.size() != 5 || viol != 0) begin
         n_fail++;
         $display("FAIL stall_stable: got %0d stall cycles %0d unstable required 5 and 0", st_d.size(), viol);
      end
      bad = sb_first_err();
      n_tests++;
      if (to_flag !== 0 || bad != -1 || got_d.size() != BEATS) begin
         n_fail++;
         $display("FAIL stall_stream: got %0d beats first bad %0d required %0d none", got_d.size(), bad, BEATS);
      end
   endtask

   task automatic test_src_last_err();
      int bad;
      run(0, 0, 1, 0, 0, 10, -1, -1, 0);
      bad = sb_first_err();
      n_tests++;
      if (err !== 1'b1) begin n_fail++; $display("FAIL err_set: got %b required 1", err); end
      n_tests++;
      if (to_flag !== 0 || bad != -1 || got_d.size() != BEATS || done_n != 1) begin
         n_fail++;
         $display("FAIL err_stream: got %0d beats first bad %0d done %0d required %0d none 1", got_d.size(), bad, done_n, BEATS);
      end
      run(1, 0, 1, 0, 0, -1, -1, -1, 0);
      n_tests++;
      if (err !== 1'b0) begin n_fail++; $display("FAIL err_clear: got %b required 0", err); end
   endtask

   task automatic test_reset_midop();
      int n, bad;
      run(0, 0, 1, 0, 0, -1, -1, 50, 0);
      reset = 0;
      #1;
      n_tests++;
      if ({op_ready, src_ready, rf_start, wb_valid, wb_last, busy, done, err} !== 8'b1000_0000 || wb_data !== '0) begin
         n_fail++;
         $display("FAIL midop_reset: got ctrl %b wb_data %h required 10000000 and 0",
                  {op_ready, src_ready, rf_start, wb_valid, wb_last, busy, done, err}, wb_data);
      end
      repeat (3) @(posedge clk);
      #1;
      reset = 1;
      n = got_d.size();
      repeat (10) @(posedge clk);
      #1;
      n_tests++;
      if (got_d.size() != n || op_ready !== 1'b1 || busy !== 1'b0) begin
         n_fail++;
         $display("FAIL midop_abandon: got %0d extra beats op_ready=%b busy=%b required 0 1 0", got_d.size() - n, op_ready, busy);
      end
      run(0, 0, 1, 0, 0, -1, -1, -1, 0);
      bad = sb_first_err();
      n_tests++;
      if (to_flag !== 0 || bad != -1 || got_d.size() != BEATS || done_n != 1) begin
         n_fail++;
         $display("FAIL midop_fresh_add: got %0d beats first bad %0d done %0d required %0d none 1", got_d.size(), bad, done_n, BEATS);
      end
   endtask

   initial begin
      test_reset();
      test_add();
      test_modes();
      test_random();
      test_backpressure();
      test_src_last_err();
      test_reset_midop();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
